amber128_wb_arbiter: RTL
========================

Name: amber128_wb_arbiter

Overview:
- Shares the single write port of the 128-bit data register file between NUM_REQ writeback sources (ALU, load unit, multiplier).
- Round-robin arbitration. Registered output drives the regfile write request.
- Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between execute/memory writeback and the register file in the core.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 128, write data width
- REG_COUNT, 32, architectural data registers
- REG_IDX_W, 5, register index width, equal to clog2(REG_COUNT)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- wb_valid_i  in  NUM_REQ  per-source write request
- wb_rw_i  in  NUM_REQ*REG_IDX_W  per-source destination index; source k occupies bits [k*REG_IDX_W +: REG_IDX_W]
- wb_wd_i  in  NUM_REQ*XLEN  per-source write data, packed the same way
- wb_ready_o  out  NUM_REQ  one-hot grant; the source is accepted this cycle
- rf_valid_o  out  1  regfile request valid
- rf_we_o  out  1  regfile write enable
- rf_rw_o  out  REG_IDX_W  regfile write index
- rf_wd_o  out  XLEN  regfile write data
- iss_valid_i  in  1  an instruction with a destination register issues
- iss_rd_i  in  REG_IDX_W  destination of the issuing instruction
- flush_i  in  1  pipeline flush; clears the scoreboard
- pend_o  out  REG_COUNT  pending-write bitmap; bit 0 is always 0

Behaviour:
- Clock and reset: clk_i is the only clock. rst_ni is asynchronous and active-low. The clock and reset names are fixed.
- Reset values: rf_valid_o=0, rf_we_o=0, rf_rw_o=0, rf_wd_o=0, pend_o=0, rr_ptr=0. wb_ready_o is combinational and is 0 while no source is valid.
- Handshake: a transfer happens when wb_valid_i[k] and wb_ready_o[k] are both 1.
  - wb_ready_o is combinational from wb_valid_i and rr_ptr, with no dependence on data.
  - At most one bit of wb_ready_o is set.
  - The regfile always accepts, so the arbiter never back-pressures internally.
  - A source must hold valid, rw and wd until it sees ready.
- Arbitration: search starts at rr_ptr and goes upward with wrap-around; the first valid source wins.
  - On a grant, rr_ptr <= (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Latency: the grant in cycle N is registered, and the write appears on rf_* in cycle N+1 with rf_valid_o=1. The regfile commits it at the end of N+1.
  - With no grant in cycle N, rf_valid_o=0 and rf_we_o=0 in N+1. rf_rw_o and rf_wd_o hold their last values.
- Index 0: a write to register 0 is still granted and consumes its slot. It produces rf_valid_o=1 with rf_we_o=0.
- Scoreboard set: iss_valid_i with iss_rd_i!=0 sets pend[iss_rd_i] at the clock edge. iss_rd_i=0 is ignored.
- Scoreboard clear: pend[rf_rw_o] clears at the edge that ends a cycle where rf_valid_o=1. This is the commit edge.
- Same-edge set and clear of one index: set wins, because a newer producer is outstanding.
- flush_i: clears every pend bit at the next edge and takes priority over a same-cycle iss_valid_i.
  - It does not cancel the registered rf_* output or the current grant. Writeback already accepted still commits.
- Duplicates: two pending writes to the same register need no count. The scoreboard is a single bit, and issue logic must not issue a second writer to a pending register.
- Reset mid-operation: all state returns to reset values immediately. An in-flight rf_valid_o drops asynchronously.

Optional Feature:
- AMBER128_WB_FIXED_PRIO_EN defined: arbitration is fixed priority, with the lowest index highest. rr_ptr is not implemented.
- Not defined: round-robin as described above.
- Latency, handshake and scoreboard are identical in both builds.

Test Plan:
- Reset, then source 1 alone with rw=5, wd=0xA5…A5 in cycle 0. Expect wb_ready_o=3'b010 in cycle 0; in cycle 1 rf_valid_o=1, rf_we_o=1, rf_rw_o=5, rf_wd_o=0xA5…A5.
- All three sources valid continuously, rw=1/2/3. Expect grants 0,1,2,0 in consecutive cycles and rf_rw_o sequence 1,2,3,1, each one cycle later. Under AMBER128_WB_FIXED_PRIO_EN, expect source 0 granted every cycle.
- iss_valid_i with iss_rd_i=7, then a writeback of rw=7 granted two cycles later. Expect pend_o[7]=1 from the issue edge until the edge ending the rf_valid_o cycle, then 0.
- In one cycle, rf_valid_o=1 with rf_rw_o=9 while iss_valid_i is set with iss_rd_i=9. Expect pend_o[9] to remain 1.
- Source 2 writes rw=0, and iss_rd_i=0. Expect the grant taken, rf_valid_o=1, rf_we_o=0, and pend_o[0]=0 throughout.
- pend_o=0x0000_00F0 and flush_i pulsed while source 0 is granted. Expect pend_o=0 next cycle and source 0's write still on rf_* with rf_we_o=1. Then assert rst_ni=0 mid-transfer and expect rf_valid_o=0 immediately.

Source files
------------

// File: rtl/amber128_wb_arbiter.sv
// Writeback arbiter for the 128-bit data regfile with a RAW pending-write scoreboard.
// Define AMBER128_WB_FIXED_PRIO_EN for fixed priority (lowest index first) instead of round-robin.
module amber128_wb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int XLEN      = 128,
    parameter int REG_COUNT = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             wb_valid_i,
    input  logic [NUM_REQ*REG_IDX_W-1:0]   wb_rw_i,
    input  logic [NUM_REQ*XLEN-1:0]        wb_wd_i,
    output logic [NUM_REQ-1:0]             wb_ready_o,
    output logic                           rf_valid_o,
    output logic                           rf_we_o,
    output logic [REG_IDX_W-1:0]           rf_rw_o,
    output logic [XLEN-1:0]                rf_wd_o,
    input  logic                           iss_valid_i,
    input  logic [REG_IDX_W-1:0]           iss_rd_i,
    input  logic                           flush_i,
    output logic [REG_COUNT-1:0]           pend_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 w_gnt;
    logic [PTR_W-1:0]     w_win;
    logic [REG_IDX_W-1:0] w_sel_rw;
    logic [XLEN-1:0]      w_sel_wd;
    logic [REG_COUNT-1:0] w_pend_nxt;

    logic                 r_valid;
    logic                 r_we;
    logic [REG_IDX_W-1:0] r_rw;
    logic [XLEN-1:0]      r_wd;
    logic [REG_COUNT-1:0] r_pend;

`ifdef AMBER128_WB_FIXED_PRIO_EN
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx = '0;
        w_gnt = 1'b0;
        w_win = '0;
        // Descending scan so the lowest valid index is the last to assign.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            v_idx = PTR_W'(i);
            if (wb_valid_i[v_idx]) begin
                w_gnt = 1'b1;
                w_win = v_idx;
            end
        end
    end
`else
    logic [PTR_W-1:0] r_rr_ptr;

    always_comb begin
        int               v_t;
        logic [PTR_W-1:0] v_idx;
        v_t   = 0;
        v_idx = '0;
        w_gnt = 1'b0;
        w_win = '0;
        // Descending distance from r_rr_ptr: the nearest valid source wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            v_t = int'(r_rr_ptr) + i;
            if (v_t >= NUM_REQ) begin
                v_t = v_t - NUM_REQ;
            end
            v_idx = PTR_W'(v_t);
            if (wb_valid_i[v_idx]) begin
                w_gnt = 1'b1;
                w_win = v_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_gnt) begin
            r_rr_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
`endif

    always_comb begin
        wb_ready_o = '0;
        if (w_gnt) begin
            wb_ready_o[w_win] = 1'b1;
        end
    end

    assign w_sel_rw = wb_rw_i[w_win*REG_IDX_W +: REG_IDX_W];
    assign w_sel_wd = wb_wd_i[w_win*XLEN +: XLEN];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rw    <= '0;
            r_wd    <= '0;
        end else if (w_gnt) begin
            r_valid <= 1'b1;
            r_we    <= (w_sel_rw != '0);
            r_rw    <= w_sel_rw;
            r_wd    <= w_sel_wd;
        end else begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end
    end

    // Set after clear: a newly issued producer outranks the committing one.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_valid) begin
            w_pend_nxt[r_rw] = 1'b0;
        end
        if (iss_valid_i) begin
            w_pend_nxt[iss_rd_i] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
        if (flush_i) begin
            w_pend_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign rf_valid_o = r_valid;
    assign rf_we_o    = r_we;
    assign rf_rw_o    = r_rw;
    assign rf_wd_o    = r_wd;
    assign pend_o     = r_pend;

endmodule
